// File: rtl/demux_1x4.sv
// ---------------------------------------------------------------------------
// demux_1x4
//   1-to-4 demultiplexer with enable and a registered lane bus.
//   The data word y is steered to the lane chosen by s. All other lanes are
//   held at zero. With e low, every lane is zero. The lane bus is a plain
//   register, so consumers see a clean, glitch-free value one cycle after
//   (s, e, y) are sampled.
//
// Ports
//   i    out  4*DATA_W  lane bus; lane k = i[k*DATA_W +: DATA_W]
//   s    in   2         lane select (0..3); s=k drives lane k
//   e    in   1         enable, active-high
//   y    in   DATA_W    data word to route
//   clk  in   1         rising-edge clock
//   rst  in   1         synchronous reset, active-high; clears every lane
// ---------------------------------------------------------------------------
module demux_1x4 #(
    parameter int DATA_W = 1
) (
    output logic [4*DATA_W-1:0] i,
    input  logic [1:0]          s,
    input  logic                e,
    input  logic [DATA_W-1:0]   y,
    input  logic                clk,
    input  logic                rst
);

    logic [4*DATA_W-1:0] i_d;
    logic [4*DATA_W-1:0] i_q;

    // Next lane bus is rebuilt from zero every cycle. Because of this, the
    // previously selected lane clears in the same cycle that a new lane is
    // loaded, and no lane can hold a stale value.
    always_comb begin
        i_d = '0;
        if (e) begin
            case (s)
                2'd0:    i_d[0*DATA_W +: DATA_W] = y;
                2'd1:    i_d[1*DATA_W +: DATA_W] = y;
                2'd2:    i_d[2*DATA_W +: DATA_W] = y;
                default: i_d[3*DATA_W +: DATA_W] = y;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i_q <= '0;
        end else begin
            i_q <= i_d;
        end
    end

    assign i = i_q;

endmodule

// File: tb/tb_demux_1x4.sv
// ---------------------------------------------------------------------------
// tb_demux_1x4
//   Directed bench for demux_1x4 (DATA_W = 1). Inputs are driven 1 ns after
//   a rising edge and the lane bus is sampled 1 ns after the following edge.
// ---------------------------------------------------------------------------
module tb_demux_1x4;

    logic [3:0] i;
    logic [1:0] s;
    logic       e;
    logic [0:0] y;
    logic       clk;
    logic       rst;

    int tests_run = 0;
    int tests_failed = 0;

    logic [3:0] exp_q[$];

    demux_1x4 #(.DATA_W(1)) dut (
        .i   (i),
        .s   (s),
        .e   (e),
        .y   (y),
        .clk (clk),
        .rst (rst)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare the lane bus against an expected value.
    task automatic check(input string tag, input logic [3:0] exp);
        tests_run++;
        assert (i === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed i=%b expected i=%b", tag, i, exp);
        end
    endtask

    // Drive one set of inputs, clock one edge, then check the lane bus.
    task automatic step(input string tag, input logic r, input logic en,
                        input logic [1:0] sel, input logic d,
                        input logic [3:0] exp);
        rst = r;
        e   = en;
        s   = sel;
        y   = d;
        @(posedge clk);
        #1;
        check(tag, exp);
    endtask

    // Independent reference for the next lane bus.
    function automatic logic [3:0] ref_lanes(input logic en, input logic [1:0] sel,
                                             input logic d);
        logic [3:0] v;
        v = 4'b0000;
        if (en) v[sel] = d;
        return v;
    endfunction

    initial begin
        logic [1:0] rs;
        logic       re;
        logic       ry;
        logic [3:0] exp;

        rst = 1'b1;
        e   = 1'b0;
        s   = 2'd0;
        y   = 1'b0;

        // 1. Reset dominates e/s/y, release loads the lane
        step("reset_edge1",   1'b1, 1'b1, 2'd2, 1'b1, 4'b0000);
        step("reset_edge2",   1'b1, 1'b1, 2'd2, 1'b1, 4'b0000);
        step("reset_release", 1'b0, 1'b1, 2'd2, 1'b1, 4'b0100);

        // 2. Select sweep, lane mapping without bit reversal
        step("sweep_s0", 1'b0, 1'b1, 2'd0, 1'b1, 4'b0001);
        step("sweep_s1", 1'b0, 1'b1, 2'd1, 1'b1, 4'b0010);
        step("sweep_s2", 1'b0, 1'b1, 2'd2, 1'b1, 4'b0100);
        step("sweep_s3", 1'b0, 1'b1, 2'd3, 1'b1, 4'b1000);

        // 3. Zero data on every lane
        step("zero_s0", 1'b0, 1'b1, 2'd0, 1'b0, 4'b0000);
        step("zero_s1", 1'b0, 1'b1, 2'd1, 1'b0, 4'b0000);
        step("zero_s2", 1'b0, 1'b1, 2'd2, 1'b0, 4'b0000);
        step("zero_s3", 1'b0, 1'b1, 2'd3, 1'b0, 4'b0000);

        // 4. Enable gating
        step("enable_off", 1'b0, 1'b0, 2'd3, 1'b1, 4'b0000);
        step("enable_on",  1'b0, 1'b1, 2'd3, 1'b1, 4'b1000);

        // Inputs changing between edges must not reach i before the next edge
        s = 2'd0;
        e = 1'b1;
        y = 1'b1;
        #3;
        check("no_comb_path", 4'b1000);
        @(posedge clk);
        #1;
        check("after_comb_change", 4'b0001);

        // 5. Simultaneous s/y change: old lane clears as new lane loads
        step("simul_s1", 1'b0, 1'b1, 2'd1, 1'b1, 4'b0010);
        step("simul_s2", 1'b0, 1'b1, 2'd2, 1'b1, 4'b0100);

        // Random s/e/y against the reference, expected values queued one cycle
        for (int n = 0; n < 16; n++) begin
            rs = 2'($urandom_range(0, 3));
            re = 1'($urandom_range(0, 1));
            ry = 1'($urandom_range(0, 1));
            if (n < 4) re = 1'b1;
            rst = 1'b0;
            s   = rs;
            e   = re;
            y   = ry;
            exp_q.push_back(ref_lanes(re, rs, ry));
            @(posedge clk);
            #1;
            exp = exp_q.pop_front();
            check($sformatf("rand_%0d", n), exp);
            tests_run++;
            assert ($countones(i) <= 1) else begin
                tests_failed++;
                $error("FAIL rand_onehot_%0d: observed i=%b expected at most one set lane", n, i);
            end
        end

        // 6. Mid-run reset
        step("midrun_load",    1'b0, 1'b1, 2'd3, 1'b1, 4'b1000);
        step("midrun_reset",   1'b1, 1'b1, 2'd3, 1'b1, 4'b0000);
        step("midrun_release", 1'b0, 1'b1, 2'd3, 1'b1, 4'b1000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
